// File: rtl/hhmm_clock_set.sv
// HH:MM real-time clock with a three-state set-mode FSM (RUN / SET_HOUR / SET_MIN),
// BCD hour/minute digits and a blink-driven per-digit blank mask.
module hhmm_clock_set #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [3:0] hora_d,
  output logic [3:0] hora_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [1:0] set_mode,
  output logic [3:0] blank_mask
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [PW-1:0] presc_r;
  logic [5:0]    sec_r;
  logic [3:0]    hora_d_r, hora_u_r, min_d_r, min_u_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_ph_r;
  logic [3:0]    blank_mask_r;

  logic          tick_s;
  logic          sec_wrap_s;
  logic          min_inc_s;
  logic          hour_inc_s;
  logic          enter_set_s;
  logic          leave_set_s;
  logic [BW-1:0] blink_cnt_next_s;
  logic          blink_ph_next_s;
  logic [3:0]    mask_next_s;
  logic [7:0]    min_next_s;
  logic [7:0]    hour_next_s;

  // Minute BCD increment, 59 wraps to 00 (carry handled by the caller).
  function automatic logic [7:0] bcd_min_inc(input logic [7:0] mm);
    logic [7:0] r;
    if (mm[3:0] >= 4'd9) begin
      r = (mm[7:4] >= 4'd5) ? 8'h00 : {mm[7:4] + 4'd1, 4'd0};
    end else begin
      r = {mm[7:4], mm[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Hour BCD increment, 23 wraps to 00.
  function automatic logic [7:0] bcd_hour_inc(input logic [7:0] hh);
    logic [7:0] r;
    if ((hh[7:4] >= 4'd2) && (hh[3:0] >= 4'd3)) begin
      r = 8'h00;
    end else if (hh[3:0] >= 4'd9) begin
      r = {hh[7:4] + 4'd1, 4'd0};
    end else begin
      r = {hh[7:4], hh[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Next-state, carry chain and blink/mask look-ahead so every output is a register.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN:      next_state_s = mode_pulse ? SET_HOUR : RUN;
      SET_HOUR: next_state_s = mode_pulse ? SET_MIN : SET_HOUR;
      SET_MIN:  next_state_s = mode_pulse ? RUN : SET_MIN;
      default:  next_state_s = RUN;
    endcase

    tick_s      = (state_r == RUN) && (presc_r == PW'(TICK_DIV - 1));
    sec_wrap_s  = tick_s && (sec_r == 6'd59);
    min_inc_s   = sec_wrap_s || ((state_r == SET_MIN) && inc_pulse && !mode_pulse);
    hour_inc_s  = (sec_wrap_s && (min_d_r == 4'd5) && (min_u_r == 4'd9)) ||
                  ((state_r == SET_HOUR) && inc_pulse && !mode_pulse);
    enter_set_s = mode_pulse && ((state_r == RUN) || (state_r == SET_HOUR));
    leave_set_s = mode_pulse && (state_r == SET_MIN);

    min_next_s  = bcd_min_inc({min_d_r, min_u_r});
    hour_next_s = bcd_hour_inc({hora_d_r, hora_u_r});

    if (enter_set_s) begin
      blink_cnt_next_s = '0;
      blink_ph_next_s  = 1'b0;
    end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
      blink_cnt_next_s = '0;
      blink_ph_next_s  = ~blink_ph_r;
    end else begin
      blink_cnt_next_s = blink_cnt_r + BW'(1);
      blink_ph_next_s  = blink_ph_r;
    end

    case (next_state_s)
      SET_HOUR: mask_next_s = blink_ph_next_s ? 4'b1100 : 4'b0000;
      SET_MIN:  mask_next_s = blink_ph_next_s ? 4'b0011 : 4'b0000;
      default:  mask_next_s = 4'b0000;
    endcase
  end

  // Mode FSM, blink generator and registered mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= RUN;
      blink_cnt_r  <= '0;
      blink_ph_r   <= 1'b0;
      blank_mask_r <= 4'b0000;
    end else begin
      state_r      <= next_state_s;
      blink_cnt_r  <= blink_cnt_next_s;
      blink_ph_r   <= blink_ph_next_s;
      blank_mask_r <= mask_next_s;
    end
  end

  // Prescaler and seconds: run only in RUN, restart cleanly when an edit is committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
      sec_r   <= 6'd0;
    end else if (leave_set_s) begin
      presc_r <= '0;
      sec_r   <= 6'd0;
    end else if (state_r == RUN) begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      if (tick_s) begin
        sec_r <= sec_wrap_s ? 6'd0 : sec_r + 6'd1;
      end
    end
  end

  // BCD minute and hour digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_d_r  <= 4'd0;
      min_u_r  <= 4'd0;
      hora_d_r <= 4'd0;
      hora_u_r <= 4'd0;
    end else begin
      if (min_inc_s) begin
        {min_d_r, min_u_r} <= min_next_s;
      end
      if (hour_inc_s) begin
        {hora_d_r, hora_u_r} <= hour_next_s;
      end
    end
  end

  assign hora_d     = hora_d_r;
  assign hora_u     = hora_u_r;
  assign min_d      = min_d_r;
  assign min_u      = min_u_r;
  assign set_mode   = state_r;
  assign blank_mask = blank_mask_r;

endmodule

// File: tb/tb_hhmm_clock_set.sv
// Directed bench for hhmm_clock_set with TICK_DIV=4, BLINK_DIV=3.
module tb_hhmm_clock_set;

  logic       clk;
  logic       reset;
  logic       mode_pulse;
  logic       inc_pulse;
  logic [3:0] hora_d, hora_u, min_d, min_u;
  logic [1:0] set_mode;
  logic [3:0] blank_mask;

  int vec_cnt = 0;
  int err_cnt = 0;

  hhmm_clock_set #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .hora_d     (hora_d),
    .hora_u     (hora_u),
    .min_d      (min_d),
    .min_u      (min_u),
    .set_mode   (set_mode),
    .blank_mask (blank_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start and finish on a falling edge, so outputs are settled on return.
  task automatic pulse(input logic m, input logic i);
    mode_pulse = m;
    inc_pulse  = i;
    @(negedge clk);
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  task automatic pulse_n(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) pulse(m, i);
  endtask

  task automatic test_reset;
    reset = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0000) begin
      err_cnt++; $display("FAIL reset_time: got %h required 0000", {hora_d, hora_u, min_d, min_u});
    end
    vec_cnt++;
    if (set_mode !== 2'd0 || blank_mask !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_mode: got mode=%0d mask=%b required 0/0000", set_mode, blank_mask);
    end
    reset = 1'b1;
  endtask

  task automatic test_run_ignore_inc;
    pulse_n(1'b0, 1'b1, 3);
    repeat (6) @(negedge clk);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0000 || set_mode !== 2'd0 || blank_mask !== 4'b0000) begin
      err_cnt++; $display("FAIL run_inc_ignored: got %h mode=%0d mask=%b required 0000 0 0000",
                          {hora_d, hora_u, min_d, min_u}, set_mode, blank_mask);
    end
  endtask

  task automatic test_hour_set;
    pulse(1'b1, 1'b0);
    vec_cnt++;
    if (set_mode !== 2'd1 || blank_mask !== 4'b0000) begin
      err_cnt++; $display("FAIL enter_set_hour: got mode=%0d mask=%b required 1/0000", set_mode, blank_mask);
    end
    pulse_n(1'b0, 1'b1, 25);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0100 || set_mode !== 2'd1) begin
      err_cnt++; $display("FAIL hour_set_25: got %h mode=%0d required 0100 mode=1",
                          {hora_d, hora_u, min_d, min_u}, set_mode);
    end
  endtask

  task automatic test_simultaneous;
    pulse(1'b1, 1'b1);
    vec_cnt++;
    if (set_mode !== 2'd2 || {hora_d, hora_u} !== 8'h01) begin
      err_cnt++; $display("FAIL mode_and_inc: got mode=%0d hours=%h required 2/01", set_mode, {hora_d, hora_u});
    end
  endtask

  // Entered SET_MIN on the edge just before this falling edge: 000-phase first.
  task automatic test_blink;
    logic [3:0] exp_mask;
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      exp_mask = (((k / 3) % 2) == 1) ? 4'b0011 : 4'b0000;
      vec_cnt++;
      if (blank_mask !== exp_mask) begin
        err_cnt++; $display("FAIL blink_k%0d: got %b required %b", k, blank_mask, exp_mask);
      end
    end
  endtask

  task automatic test_min_set_no_carry;
    pulse_n(1'b0, 1'b1, 59);
    vec_cnt++;
    if ({min_d, min_u} !== 8'h59) begin
      err_cnt++; $display("FAIL min_set_59: got %h required 59", {min_d, min_u});
    end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 4);
    pulse(1'b1, 1'b0);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0559 || set_mode !== 2'd2) begin
      err_cnt++; $display("FAIL preset_0559: got %h mode=%0d required 0559 mode=2",
                          {hora_d, hora_u, min_d, min_u}, set_mode);
    end
    pulse(1'b0, 1'b1);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0500) begin
      err_cnt++; $display("FAIL min_wrap_no_carry: got %h required 0500", {hora_d, hora_u, min_d, min_u});
    end
  endtask

  task automatic test_rollover;
    logic ok;
    pulse_n(1'b0, 1'b1, 59);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 18);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h2359 || set_mode !== 2'd0) begin
      err_cnt++; $display("FAIL preset_2359: got %h mode=%0d required 2359 mode=0",
                          {hora_d, hora_u, min_d, min_u}, set_mode);
    end
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      ok = (hora_d <= 4'd2) && (hora_u <= 4'd9) && !(hora_d == 4'd2 && hora_u > 4'd3) &&
           (min_d <= 4'd5) && (min_u <= 4'd9) && (blank_mask == 4'b0000);
      vec_cnt++;
      if (!ok) begin
        err_cnt++; $display("FAIL run_valid_c%0d: got %h mask=%b required valid BCD, mask 0000",
                            i, {hora_d, hora_u, min_d, min_u}, blank_mask);
      end
      if (i == 239) begin
        vec_cnt++;
        if ({hora_d, hora_u, min_d, min_u} !== 16'h2359) begin
          err_cnt++; $display("FAIL before_rollover: got %h required 2359", {hora_d, hora_u, min_d, min_u});
        end
      end
    end
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0000) begin
      err_cnt++; $display("FAIL rollover_60th_tick: got %h required 0000", {hora_d, hora_u, min_d, min_u});
    end
  endtask

  task automatic test_reset_mid_edit;
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 14);
    vec_cnt++;
    if ({hora_d, hora_u} !== 8'h14 || set_mode !== 2'd1) begin
      err_cnt++; $display("FAIL preset_14: got %h mode=%0d required 14 mode=1", {hora_d, hora_u}, set_mode);
    end
    #2 reset = 1'b0;
    #1;
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0000 || set_mode !== 2'd0 || blank_mask !== 4'b0000) begin
      err_cnt++; $display("FAIL async_reset: got %h mode=%0d mask=%b required 0000 0 0000",
                          {hora_d, hora_u, min_d, min_u}, set_mode, blank_mask);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // First minute after release: 60 ticks of 4 cycles land on the 240th edge.
  task automatic test_first_tick;
    repeat (239) @(negedge clk);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0000) begin
      err_cnt++; $display("FAIL edge239_after_reset: got %h required 0000", {hora_d, hora_u, min_d, min_u});
    end
    @(negedge clk);
    vec_cnt++;
    if ({hora_d, hora_u, min_d, min_u} !== 16'h0001) begin
      err_cnt++; $display("FAIL edge240_after_reset: got %h required 0001", {hora_d, hora_u, min_d, min_u});
    end
  endtask

  initial begin
    test_reset;
    test_run_ignore_inc;
    test_hour_set;
    test_simultaneous;
    test_blink;
    test_min_set_no_carry;
    test_rollover;
    test_reset_mid_edit;
    test_first_tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
